// File: rtl/fir_s2p3_packer.sv
// fir_s2p3_packer: 1-to-3 serial-to-parallel packer feeding a 3-way unfolded FIR (rev 1.0).
// Define FIR_S2P3_FLUSH_EN to let FLUSH close a partial group with zero padding.
`default_nettype none

module fir_s2p3_packer #(
  parameter int NBIT = 9
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            VIN,
  input  logic [NBIT-1:0] DIN,
  input  logic            FLUSH,
  output logic            VOUT,
  output logic [NBIT-1:0] DOUT3k,
  output logic [NBIT-1:0] DOUT3k1,
  output logic [NBIT-1:0] DOUT3k2
);

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } phase_t;

  phase_t          state, state_nxt;
  logic [NBIT-1:0] slot0, slot1;
  logic [NBIT-1:0] grp0, grp1, grp2;
  logic            emit;

`ifndef FIR_S2P3_FLUSH_EN
  logic unused_flush;
  assign unused_flush = FLUSH;
`endif

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    grp0      = slot0;
    grp1      = slot1;
    grp2      = DIN;

    if (VIN) begin
      case (state)
        P0: state_nxt = P1;
        P1: state_nxt = P2;
        P2: begin
          state_nxt = P0;
          emit      = 1'b1;
        end
        default: state_nxt = P0;
      endcase
    end

`ifdef FIR_S2P3_FLUSH_EN
    // The incoming sample is captured before the flush pads the rest with zeros.
    if (FLUSH) begin
      if (VIN) begin
        case (state)
          P0: begin
            state_nxt = P0;
            emit      = 1'b1;
            grp0      = DIN;
            grp1      = '0;
            grp2      = '0;
          end
          P1: begin
            state_nxt = P0;
            emit      = 1'b1;
            grp1      = DIN;
            grp2      = '0;
          end
          default: ;
        endcase
      end else begin
        case (state)
          P1: begin
            state_nxt = P0;
            emit      = 1'b1;
            grp1      = '0;
            grp2      = '0;
          end
          P2: begin
            state_nxt = P0;
            emit      = 1'b1;
            grp2      = '0;
          end
          default: ;
        endcase
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= P0;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot0   <= '0;
      slot1   <= '0;
      VOUT    <= 1'b0;
      DOUT3k  <= '0;
      DOUT3k1 <= '0;
      DOUT3k2 <= '0;
    end else begin
      if (VIN && (state == P0)) slot0 <= DIN;
      if (VIN && (state == P1)) slot1 <= DIN;
      VOUT <= emit;
      if (emit) begin
        DOUT3k  <= grp0;
        DOUT3k1 <= grp1;
        DOUT3k2 <= grp2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_s2p3_packer.sv
// tb_fir_s2p3_packer: scoreboard bench for fir_s2p3_packer; follows FIR_S2P3_FLUSH_EN if defined.
`default_nettype none

module tb_fir_s2p3_packer;

  localparam int NBIT = 9;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            VIN = 1'b0;
  logic [NBIT-1:0] DIN = '0;
  logic            FLUSH = 1'b0;
  logic            VOUT;
  logic [NBIT-1:0] DOUT3k, DOUT3k1, DOUT3k2;

  fir_s2p3_packer #(.NBIT(NBIT)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .VIN    (VIN),
    .DIN    (DIN),
    .FLUSH  (FLUSH),
    .VOUT   (VOUT),
    .DOUT3k (DOUT3k),
    .DOUT3k1(DOUT3k1),
    .DOUT3k2(DOUT3k2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NBIT-1:0] a, b, c;
    int              due;
  } grp_t;

  grp_t            sb[$];
  int              cycle = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  int              ph = 0;
  logic [NBIT-1:0] h0 = '0, h1 = '0;
  logic [NBIT-1:0] last0 = '0, last1 = '0, last2 = '0;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  task automatic push(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input logic [NBIT-1:0] c);
    grp_t g;
    g.a = a; g.b = b; g.c = c; g.due = cycle + 1;
    sb.push_back(g);
  endtask

  // Drives one cycle of inputs and advances the reference model.
  task automatic drive(input logic v, input logic [NBIT-1:0] d, input logic f);
    @(posedge CLK); #1;
    VIN = v; DIN = d; FLUSH = f;
    if (v) begin
      case (ph)
        0: begin h0 = d; ph = 1; end
        1: begin h1 = d; ph = 2; end
        default: begin push(h0, h1, d); ph = 0; end
      endcase
    end
`ifdef FIR_S2P3_FLUSH_EN
    if (f) begin
      if (ph == 1) push(h0, '0, '0);
      else if (ph == 2) push(h0, h1, '0);
      ph = 0;
    end
`endif
  endtask

  task automatic send(input logic [NBIT-1:0] d);
    drive(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1;
    VIN = 1'b0; FLUSH = 1'b0; RST = 1'b1;
    ph = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      check("rst_vout", {31'd0, VOUT}, 32'd0);
      check("rst_d0", {23'd0, DOUT3k}, 32'd0);
      check("rst_d1", {23'd0, DOUT3k1}, 32'd0);
      check("rst_d2", {23'd0, DOUT3k2}, 32'd0);
      last0 = '0; last1 = '0; last2 = '0;
    end else begin
      logic exp_v;
      exp_v = (sb.size() > 0) && (sb[0].due == cycle);
      check("vout", {31'd0, VOUT}, {31'd0, exp_v});
      if (exp_v) begin
        grp_t g;
        g = sb.pop_front();
        check("dout3k", {23'd0, DOUT3k}, {23'd0, g.a});
        check("dout3k1", {23'd0, DOUT3k1}, {23'd0, g.b});
        check("dout3k2", {23'd0, DOUT3k2}, {23'd0, g.c});
        last0 = g.a; last1 = g.b; last2 = g.c;
      end else begin
        check("hold", {5'd0, DOUT3k, DOUT3k1, DOUT3k2}, {5'd0, last0, last1, last2});
      end
      // A group that was due but never arrived must not stall the queue.
      while (sb.size() > 0 && sb[0].due < cycle) begin
        check("missed_group", {31'd0, VOUT}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    for (int i = 1; i <= 6; i++) send(NBIT'(i));
    idle(3);

    send(9'h100); idle(2);
    send(9'h0FF); idle(2);
    send(9'h1FF); idle(5);
    check("hold_after_gap", {5'd0, DOUT3k, DOUT3k1, DOUT3k2}, {5'd0, 9'h100, 9'h0FF, 9'h1FF});

    send(9'd7); send(9'd8);
    pulse_reset();
    send(9'd9); send(9'd10); send(9'd11);
    idle(3);

`ifdef FIR_S2P3_FLUSH_EN
    send(9'd5); drive(1'b0, '0, 1'b1); idle(2);
    send(9'd7); send(9'd8); drive(1'b1, 9'd9, 1'b1); idle(2);
    drive(1'b0, '0, 1'b1); idle(2);
    send(9'd3); drive(1'b1, 9'd4, 1'b1); idle(2);
    drive(1'b1, 9'd12, 1'b1); idle(2);
    send(9'd20); send(9'd21); drive(1'b0, '0, 1'b1); idle(2);
`else
    send(9'd5); drive(1'b0, '0, 1'b1); idle(3);
    send(9'd6); send(9'd7); idle(3);
`endif

    accepted = 0;
    while (accepted < 30) begin
      if ($urandom_range(1, 0) == 1) begin
        send(NBIT'($urandom));
        accepted++;
      end else begin
        idle(1);
      end
    end
    idle(4);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
